// File: rtl/tone_scheduler.sv
// rtl/tone_scheduler.sv - key-driven tone selection and ROM melody playback scheduler
//
// Ports:
//   clk_5MHz  in   1  sole clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   key_in    in   4  raw key levels (bit0 Hdo, bit1 Hre, bit2 Hmi, bit3 Hfa)
//   play_req  in   1  one-cycle pulse, start melody from index 0
//   stop_req  in   1  one-cycle pulse, abort melody
//   reload    out 14  tone-divider reload value (registered)
//   tone_en   out  1  tone generator enable (registered)
//   busy      out  1  high whenever the scheduler is not idle (registered)
//   note_idx  out  4  current melody ROM index (registered)
module tone_scheduler #(
  parameter int DEB_CYCLES = 50000,
  parameter int TICK_DIV   = 50000,
  parameter int NOTE_TICKS = 25,
  parameter int REST_TICKS = 5
) (
  input  logic        clk_5MHz,
  input  logic        rst_n,
  input  logic [3:0]  key_in,
  input  logic        play_req,
  input  logic        stop_req,
  output logic [13:0] reload,
  output logic        tone_en,
  output logic        busy,
  output logic [3:0]  note_idx
);

  localparam int DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX = (NOTE_TICKS > REST_TICKS) ? NOTE_TICKS : REST_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] NOTE_LOAD  = TW'(NOTE_TICKS);
  localparam logic [TW-1:0] REST_LOAD  = TW'(REST_TICKS);

  typedef enum logic [1:0] {IDLE, KEY, NOTE, GAP} state_t;

  // Melody ROM: 0 = rest, 1..4 = Hdo..Hfa, 7 = end of melody.
  function automatic logic [2:0] rom_code(input logic [3:0] idx);
    case (idx)
      4'd0:    rom_code = 3'd1;
      4'd1:    rom_code = 3'd2;
      4'd2:    rom_code = 3'd3;
      4'd3:    rom_code = 3'd4;
      4'd4:    rom_code = 3'd3;
      4'd5:    rom_code = 3'd2;
      4'd6:    rom_code = 3'd1;
      4'd7:    rom_code = 3'd0;
      4'd8:    rom_code = 3'd1;
      4'd9:    rom_code = 3'd3;
      4'd10:   rom_code = 3'd2;
      4'd11:   rom_code = 3'd4;
      4'd12:   rom_code = 3'd1;
      4'd13:   rom_code = 3'd0;
      4'd14:   rom_code = 3'd1;
      default: rom_code = 3'd7;
    endcase
  endfunction

  // Rest and end codes map to 0, so reload doubles as the "sounding" flag.
  function automatic logic [13:0] tone_of_code(input logic [2:0] code);
    case (code)
      3'd1:    tone_of_code = 14'd6826;
      3'd2:    tone_of_code = 14'd7871;
      3'd3:    tone_of_code = 14'd8798;
      3'd4:    tone_of_code = 14'd9224;
      default: tone_of_code = 14'd0;
    endcase
  endfunction

  // Lowest-index key wins; result uses the same code space as the ROM.
  function automatic logic [2:0] key_code(input logic [3:0] k);
    if (k[0])      key_code = 3'd1;
    else if (k[1]) key_code = 3'd2;
    else if (k[2]) key_code = 3'd3;
    else if (k[3]) key_code = 3'd4;
    else           key_code = 3'd0;
  endfunction

  logic [3:0]    sync1, sync2, deb;
  logic [DW-1:0] deb_cnt [4];
  logic [PW-1:0] presc;
  logic [TW-1:0] dur;
  state_t        state, state_nxt;
  logic [3:0]    idx_nxt;
  logic [2:0]    code_cur, code_nxt;
  logic [13:0]   reload_nxt;
  logic          tone_en_nxt, busy_nxt;
  logic          tick, expire, key_any, enter_note, enter_gap;

  assign key_any    = |deb;
  assign code_cur   = rom_code(note_idx);
  assign tick       = (presc == PRESC_LAST);
  assign expire     = tick && (dur == TW'(1));
  assign enter_note = (state_nxt == NOTE) && (state != NOTE);
  assign enter_gap  = (state_nxt == GAP) && (state != GAP);

  // Per-bit synchronizer and debounce: the counter only runs while the
  // synchronized level disagrees with the debounced level.
  always_ff @(posedge clk_5MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Tick prescaler restarts on every NOTE/GAP entry so each duration is exact.
  always_ff @(posedge clk_5MHz or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      dur   <= '0;
    end else begin
      if (enter_note || enter_gap || tick || !(state == NOTE || state == GAP))
        presc <= '0;
      else
        presc <= presc + PW'(1);

      if (enter_note)
        dur <= NOTE_LOAD;
      else if (enter_gap)
        dur <= REST_LOAD;
      else if (tick && dur != '0)
        dur <= dur - TW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = note_idx;
    case (state)
      IDLE: begin
        if (key_any) begin
          state_nxt = KEY;
        end else if (play_req) begin
          state_nxt = NOTE;
          idx_nxt   = 4'd0;
        end
      end
      KEY: begin
        if (!key_any) state_nxt = IDLE;
      end
      NOTE: begin
        if (stop_req)              state_nxt = IDLE;
        else if (key_any)          state_nxt = KEY;
        else if (code_cur == 3'd7) state_nxt = IDLE;
        else if (expire)           state_nxt = GAP;
      end
      GAP: begin
        if (stop_req) begin
          state_nxt = IDLE;
        end else if (key_any) begin
          state_nxt = KEY;
        end else if (expire) begin
          idx_nxt   = note_idx + 4'd1;
          state_nxt = (note_idx == 4'd15) ? IDLE : NOTE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are derived from the next state so that the registered copies
    // line up with the state register.
    code_nxt    = rom_code(idx_nxt);
    reload_nxt  = 14'd0;
    tone_en_nxt = 1'b0;
    busy_nxt    = (state_nxt != IDLE);
    case (state_nxt)
      KEY: begin
        reload_nxt  = tone_of_code(key_code(deb));
        tone_en_nxt = 1'b1;
      end
      NOTE: begin
        reload_nxt  = tone_of_code(code_nxt);
        tone_en_nxt = (reload_nxt != 14'd0);
      end
      GAP: begin
        reload_nxt = reload;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_5MHz or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      reload   <= '0;
      tone_en  <= 1'b0;
      busy     <= 1'b0;
      note_idx <= '0;
    end else begin
      state    <= state_nxt;
      reload   <= reload_nxt;
      tone_en  <= tone_en_nxt;
      busy     <= busy_nxt;
      note_idx <= idx_nxt;
    end
  end

endmodule

// File: tb/tb_tone_scheduler.sv
// tb/tb_tone_scheduler.sv - directed self-checking bench for tone_scheduler
module tb_tone_scheduler;

  logic        clk_5MHz = 1'b0;
  logic        rst_n    = 1'b0;
  logic [3:0]  key_in   = 4'b0000;
  logic        play_req = 1'b0;
  logic        stop_req = 1'b0;
  logic [13:0] reload;
  logic        tone_en;
  logic        busy;
  logic [3:0]  note_idx;

  int n_pass  = 0;
  int n_total = 0;

  tone_scheduler #(
    .DEB_CYCLES(3),
    .TICK_DIV  (4),
    .NOTE_TICKS(3),
    .REST_TICKS(1)
  ) dut (
    .clk_5MHz(clk_5MHz),
    .rst_n   (rst_n),
    .key_in  (key_in),
    .play_req(play_req),
    .stop_req(stop_req),
    .reload  (reload),
    .tone_en (tone_en),
    .busy    (busy),
    .note_idx(note_idx)
  );

  always #5 clk_5MHz = ~clk_5MHz;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_5MHz);
    #1;
  endtask

  task automatic start_play;
    play_req = 1'b1;
    step(1);
    play_req = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(2);
    n_total++;
    if ({busy, tone_en, reload, note_idx} !== 20'd0)
      $display("FAIL reset_hold got busy=%0d tone_en=%0d reload=%0d idx=%0d want all 0", busy, tone_en, reload, note_idx);
    else n_pass++;
    rst_n = 1'b1;
    step(1);
    n_total++;
    if (busy !== 1'b0 || tone_en !== 1'b0)
      $display("FAIL reset_release got busy=%0d tone_en=%0d want 0/0", busy, tone_en);
    else n_pass++;
  endtask

  task automatic test_key_single;
    key_in = 4'b0100;
    step(5);
    n_total++;
    if (tone_en !== 1'b0) $display("FAIL key_early got tone_en=%0d want 0", tone_en);
    else n_pass++;
    step(1);
    n_total++;
    if (tone_en !== 1'b1 || reload !== 14'd8798 || busy !== 1'b1)
      $display("FAIL key_on got tone_en=%0d reload=%0d busy=%0d want 1/8798/1", tone_en, reload, busy);
    else n_pass++;
    key_in = 4'b0000;
    step(5);
    n_total++;
    if (tone_en !== 1'b1) $display("FAIL key_release_early got tone_en=%0d want 1", tone_en);
    else n_pass++;
    step(1);
    n_total++;
    if (tone_en !== 1'b0 || busy !== 1'b0 || reload !== 14'd0)
      $display("FAIL key_off got tone_en=%0d busy=%0d reload=%0d want 0/0/0", tone_en, busy, reload);
    else n_pass++;
  endtask

  task automatic test_key_priority;
    int dropped;
    key_in = 4'b1010;
    step(6);
    n_total++;
    if (tone_en !== 1'b1 || reload !== 14'd7871)
      $display("FAIL prio_two_keys got tone_en=%0d reload=%0d want 1/7871", tone_en, reload);
    else n_pass++;
    key_in  = 4'b1000;
    dropped = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (tone_en !== 1'b1) dropped++;
      if (i == 5) begin
        n_total++;
        if (reload !== 14'd7871) $display("FAIL prio_before_change got reload=%0d want 7871", reload);
        else n_pass++;
      end
      if (i == 6) begin
        n_total++;
        if (reload !== 14'd9224) $display("FAIL prio_after_change got reload=%0d want 9224", reload);
        else n_pass++;
      end
    end
    n_total++;
    if (dropped != 0) $display("FAIL prio_no_drop got %0d low cycles want 0", dropped);
    else n_pass++;
    key_in = 4'b0000;
    step(6);
    n_total++;
    if (busy !== 1'b0) $display("FAIL prio_release got busy=%0d want 0", busy);
    else n_pass++;
  endtask

  task automatic test_glitch_and_race;
    int active;
    key_in = 4'b0001;
    step(2);
    key_in = 4'b0000;
    active = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (busy !== 1'b0 || tone_en !== 1'b0) active++;
    end
    n_total++;
    if (active != 0) $display("FAIL glitch got %0d active cycles want 0", active);
    else n_pass++;
    key_in = 4'b0100;
    step(5);
    play_req = 1'b1;
    step(1);
    play_req = 1'b0;
    n_total++;
    if (busy !== 1'b1 || tone_en !== 1'b1 || reload !== 14'd8798)
      $display("FAIL race_key_play got busy=%0d tone_en=%0d reload=%0d want 1/1/8798", busy, tone_en, reload);
    else n_pass++;
    play_req = 1'b1;
    step(1);
    play_req = 1'b0;
    n_total++;
    if (reload !== 14'd8798) $display("FAIL play_in_key got reload=%0d want 8798", reload);
    else n_pass++;
    key_in = 4'b0000;
    step(6);
    n_total++;
    if (busy !== 1'b0 || tone_en !== 1'b0)
      $display("FAIL key_exit_after_play got busy=%0d tone_en=%0d want 0/0", busy, tone_en);
    else n_pass++;
  endtask

  task automatic test_play_notes;
    int note_bad, gap_bad;
    start_play();
    n_total++;
    if (reload !== 14'd6826 || tone_en !== 1'b1 || busy !== 1'b1 || note_idx !== 4'd0)
      $display("FAIL play_start got reload=%0d tone_en=%0d busy=%0d idx=%0d want 6826/1/1/0", reload, tone_en, busy, note_idx);
    else n_pass++;
    note_bad = 0;
    gap_bad  = 0;
    for (int c = 1; c <= 16; c++) begin
      step(1);
      if (c <= 11 && (tone_en !== 1'b1 || reload !== 14'd6826)) note_bad++;
      if (c >= 12 && c <= 15 && (tone_en !== 1'b0 || reload !== 14'd6826)) gap_bad++;
    end
    n_total++;
    if (note_bad != 0) $display("FAIL note0_length got %0d bad cycles want 0", note_bad);
    else n_pass++;
    n_total++;
    if (gap_bad != 0) $display("FAIL gap0_length got %0d bad cycles want 0", gap_bad);
    else n_pass++;
    n_total++;
    if (reload !== 14'd7871 || tone_en !== 1'b1 || note_idx !== 4'd1)
      $display("FAIL note1_start got reload=%0d tone_en=%0d idx=%0d want 7871/1/1", reload, tone_en, note_idx);
    else n_pass++;
    stop_req = 1'b1;
    step(1);
    stop_req = 1'b0;
    n_total++;
    if (busy !== 1'b0 || tone_en !== 1'b0) $display("FAIL stop_note1 got busy=%0d tone_en=%0d want 0/0", busy, tone_en);
    else n_pass++;
  endtask

  task automatic test_melody_full;
    int zeros7;
    start_play();
    zeros7 = 0;
    for (int c = 1; c <= 246; c++) begin
      step(1);
      if (note_idx == 4'd7 && busy === 1'b1 && tone_en === 1'b0) zeros7++;
      if (c == 112) begin
        n_total++;
        if (note_idx !== 4'd7 || tone_en !== 1'b0 || reload !== 14'd0)
          $display("FAIL rest_note got idx=%0d tone_en=%0d reload=%0d want 7/0/0", note_idx, tone_en, reload);
        else n_pass++;
      end
      if (c == 128) begin
        n_total++;
        if (note_idx !== 4'd8 || tone_en !== 1'b1 || reload !== 14'd6826)
          $display("FAIL after_rest got idx=%0d tone_en=%0d reload=%0d want 8/1/6826", note_idx, tone_en, reload);
        else n_pass++;
      end
      if (c == 236) begin
        n_total++;
        if (note_idx !== 4'd14 || tone_en !== 1'b0 || reload !== 14'd6826)
          $display("FAIL gap14_hold got idx=%0d tone_en=%0d reload=%0d want 14/0/6826", note_idx, tone_en, reload);
        else n_pass++;
      end
      if (c == 240) begin
        n_total++;
        if (note_idx !== 4'd15 || busy !== 1'b1 || tone_en !== 1'b0)
          $display("FAIL end_code got idx=%0d busy=%0d tone_en=%0d want 15/1/0", note_idx, busy, tone_en);
        else n_pass++;
      end
      if (c == 241) begin
        n_total++;
        if (busy !== 1'b0 || note_idx !== 4'd15)
          $display("FAIL end_idle got busy=%0d idx=%0d want 0/15", busy, note_idx);
        else n_pass++;
      end
    end
    n_total++;
    if (busy !== 1'b0 || note_idx !== 4'd15 || tone_en !== 1'b0)
      $display("FAIL no_wrap got busy=%0d idx=%0d tone_en=%0d want 0/15/0", busy, note_idx, tone_en);
    else n_pass++;
    n_total++;
    if (zeros7 != 16) $display("FAIL rest_plus_gap got %0d cycles want 16", zeros7);
    else n_pass++;
  endtask

  task automatic test_stop;
    start_play();
    for (int c = 1; c <= 50; c++) begin
      step(1);
      play_req = (c == 20);
    end
    play_req = 1'b0;
    n_total++;
    if (note_idx !== 4'd3 || busy !== 1'b1 || reload !== 14'd9224)
      $display("FAIL no_restart got idx=%0d busy=%0d reload=%0d want 3/1/9224", note_idx, busy, reload);
    else n_pass++;
    stop_req = 1'b1;
    step(1);
    stop_req = 1'b0;
    n_total++;
    if (busy !== 1'b0 || tone_en !== 1'b0 || reload !== 14'd0)
      $display("FAIL stop_idx3 got busy=%0d tone_en=%0d reload=%0d want 0/0/0", busy, tone_en, reload);
    else n_pass++;
    step(3);
    n_total++;
    if (busy !== 1'b0) $display("FAIL stop_stays_idle got busy=%0d want 0", busy);
    else n_pass++;
  endtask

  task automatic test_stop_key_race;
    start_play();
    key_in = 4'b0010;
    step(5);
    n_total++;
    if (busy !== 1'b1 || reload !== 14'd6826)
      $display("FAIL race_pre got busy=%0d reload=%0d want 1/6826", busy, reload);
    else n_pass++;
    stop_req = 1'b1;
    step(1);
    stop_req = 1'b0;
    n_total++;
    if (busy !== 1'b0 || tone_en !== 1'b0)
      $display("FAIL race_stop_wins got busy=%0d tone_en=%0d want 0/0", busy, tone_en);
    else n_pass++;
    step(1);
    n_total++;
    if (busy !== 1'b1 || tone_en !== 1'b1 || reload !== 14'd7871)
      $display("FAIL race_key_follows got busy=%0d tone_en=%0d reload=%0d want 1/1/7871", busy, tone_en, reload);
    else n_pass++;
    key_in = 4'b0000;
    step(6);
    n_total++;
    if (busy !== 1'b0) $display("FAIL race_release got busy=%0d want 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset_gap;
    start_play();
    step(45);
    n_total++;
    if (note_idx !== 4'd2 || tone_en !== 1'b0 || reload !== 14'd8798 || busy !== 1'b1)
      $display("FAIL gap2_pre got idx=%0d tone_en=%0d reload=%0d busy=%0d want 2/0/8798/1", note_idx, tone_en, reload, busy);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, tone_en, reload, note_idx} !== 20'd0)
      $display("FAIL async_reset got busy=%0d tone_en=%0d reload=%0d idx=%0d want all 0", busy, tone_en, reload, note_idx);
    else n_pass++;
    step(1);
    #2;
    rst_n = 1'b1;
    step(1);
    n_total++;
    if (busy !== 1'b0 || tone_en !== 1'b0 || note_idx !== 4'd0)
      $display("FAIL post_reset_idle got busy=%0d tone_en=%0d idx=%0d want 0/0/0", busy, tone_en, note_idx);
    else n_pass++;
    step(6);
    n_total++;
    if (busy !== 1'b0) $display("FAIL melody_abandoned got busy=%0d want 0", busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_key_single();
    test_key_priority();
    test_glitch_and_race();
    test_play_notes();
    test_melody_full();
    test_stop();
    test_stop_key_race();
    test_reset_gap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
